// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if
//   Bundles the requester-side and result-side handshake signals of
//   gray_conv_arbiter so the block and its neighbours connect through a
//   single port.
//
//   Signals:
//     req_valid  [NREQ]        requester i has data on slice i of req_data
//     req_data   [NREQ*WIDTH]  slice i = req_data[i*WIDTH +: WIDTH]
//     req_ready  [NREQ]        one-hot grant back to the requesters
//     out_valid                result register holds a result
//     out_ready                downstream accepts the result
//     out_code   [WIDTH]       Gray code of the granted value
//     out_id     [ID_W]        index of the requester that produced out_code
//
//   Modports:
//     master  drives requests and out_ready (requesters + downstream side)
//     slave   the arbiter/converter itself
interface gray_conv_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_code;
  logic [ID_W-1:0]       out_id;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  out_valid,
    output out_ready,
    input  out_code,
    input  out_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output out_valid,
    input  out_ready,
    output out_code,
    output out_id
  );

endinterface

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Shares one binary-to-Gray conversion stage (g = b ^ (b >> 1)) between
//   NREQ requesters. A round-robin arbiter picks one valid requester per
//   cycle whenever the single-entry output register can take a result; the
//   converted code is registered together with the winner's index.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   gray_conv_arbiter_if.slave
//             req_valid/req_data/req_ready  per-requester handshake
//             out_valid/out_ready           result handshake
//             out_code/out_id               registered result and its source
//
//   Parameters:
//     NREQ   number of requesters (2..8)
//     WIDTH  code width in bits
//     ID_W   width of out_id, clog2(NREQ)
module gray_conv_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  gray_conv_arbiter_if.slave     bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  code_q, code_d;

  logic              accept;
  logic              found;
  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic [NREQ-1:0]   grant_vec;
  logic [WIDTH-1:0]  grant_data;
  int                idx;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // The output register can take a new result when it is empty, or when
  // the current result leaves in this same cycle (drain and refill).
  assign accept = (state_q == EMPTY) || (bus.out_ready && (state_q == FULL));

  // Round-robin search starting at ptr_q and wrapping modulo NREQ. Only
  // req_valid feeds the search, so req_ready never depends on req_data.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
        found                    = 1'b1;
        grant_idx                = idx[ID_W-1:0];
        grant_vec[idx[ID_W-1:0]] = 1'b1;
      end
    end
  end

  assign grant_any     = accept && found;
  assign bus.req_ready = accept ? grant_vec : '0;
  assign grant_data    = bus.req_data[grant_idx*WIDTH +: WIDTH];

  // Next-state logic. A grant always loads the register and advances the
  // pointer past the winner; without a grant a full register only empties
  // when downstream takes it, leaving code/id at their last values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    code_d  = code_q;
    if (grant_any) begin
      state_d = FULL;
      code_d  = to_gray(grant_data);
      id_d    = grant_idx;
      if (grant_idx == ID_W'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + ID_W'(1);
      end
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  // State and result registers. Reset discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      code_q  <= code_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_code  = code_q;
  assign bus.out_id    = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter
//   Directed testbench for gray_conv_arbiter (NREQ=4, WIDTH=4). A
//   behavioural model tracks the expected result register and round-robin
//   pointer; a compare process checks every output on each falling edge,
//   and the directed sequence adds hand-computed literal expectations.
module tb_gray_conv_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  gray_conv_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  gray_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: whether a result is held, its value and source, and the
  // index the next round-robin search starts at.
  bit              model_ready = 1'b0;
  bit              m_full      = 1'b0;
  logic [WIDTH-1:0] m_code     = '0;
  int              m_id        = 0;
  int              m_ptr       = 0;

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  // Per-bit conversion rule: top bit copied, each lower bit is the XOR of
  // itself and its upper neighbour.
  function automatic logic [WIDTH-1:0] spec_gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  // Winner of a search starting at ptr, or -1 when nobody is valid.
  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) begin
        return (ptr + k) % NREQ;
      end
    end
    return -1;
  endfunction

  function automatic int next_grant();
    if (m_full && !bus.out_ready) begin
      return -1;
    end
    return pick(m_ptr, bus.req_valid);
  endfunction

  function automatic logic [WIDTH-1:0] slice_of(input int g);
    return bus.req_data[g*WIDTH +: WIDTH];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs of the ending cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_full      <= 1'b0;
      m_code      <= '0;
      m_id        <= 0;
      m_ptr       <= 0;
      model_ready <= 1'b1;
    end else if (model_ready) begin
      if (next_grant() >= 0) begin
        m_full <= 1'b1;
        m_code <= spec_gray(slice_of(next_grant()));
        m_id   <= next_grant();
        m_ptr  <= (next_grant() + 1) % NREQ;
      end else if (m_full && bus.out_ready) begin
        m_full <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (model_ready) begin
      check_output("cmp_req_ready", 32'(bus.req_ready),
                   (next_grant() >= 0) ? (32'd1 << next_grant()) : 32'd0);
      check_output("cmp_out_valid", 32'(bus.out_valid), 32'(m_full));
      check_output("cmp_out_code", 32'(bus.out_code), 32'(m_code));
      check_output("cmp_out_id", 32'(bus.out_id), 32'(m_id));
    end
  end

  task automatic apply_stimulus(input logic [3:0] v, input logic [15:0] d,
                                input logic ordy);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input string name, input logic [3:0] exp);
    #2;
    check_output(name, 32'(bus.req_ready), 32'(exp));
  endtask

  task automatic check_result(input string name, input logic v,
                              input logic [3:0] code, input logic [1:0] id);
    check_output({name, "_valid"}, 32'(bus.out_valid), 32'(v));
    check_output({name, "_code"}, 32'(bus.out_code), 32'(code));
    check_output({name, "_id"}, 32'(bus.out_id), 32'(id));
  endtask

  logic [3:0] t4_exp [7] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000,
                             4'b0001, 4'b1000, 4'b0001};
  logic [3:0] t2_code [4] = '{4'b0010, 4'b0110, 4'b0111, 4'b0101};

  initial begin
    apply_stimulus(4'b0000, 16'h0000, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check_result("reset", 1'b0, 4'h0, 2'd0);
    rst = 1'b0;
    check_ready("reset_ready", 4'b0000);

    // T1: single request from requester 1
    apply_stimulus(4'b0010, 16'h0050, 1'b1);
    check_ready("t1_ready", 4'b0010);
    tick();
    check_result("t1", 1'b1, 4'b0111, 2'd1);

    // Move pointer back to 0 by granting requester 3 once
    apply_stimulus(4'b1000, 16'h0000, 1'b1);
    check_ready("t2_pre_ready", 4'b1000);
    tick();

    // T2: all four requesting, slices 3,4,5,6
    apply_stimulus(4'b1111, 16'h6543, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check_ready("t2_ready", 4'(1 << k));
      tick();
      check_result("t2", 1'b1, t2_code[k], 2'(k));
    end

    // T3: load 1100 from requester 0, then backpressure for 5 cycles
    apply_stimulus(4'b0001, 16'h0008, 1'b1);
    tick();
    check_result("t3_load", 1'b1, 4'b1100, 2'd0);
    apply_stimulus(4'b1111, 16'h1234, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check_ready("t3_hold_ready", 4'b0000);
      tick();
      check_result("t3_hold", 1'b1, 4'b1100, 2'd0);
    end
    apply_stimulus(4'b1111, 16'h1234, 1'b1);
    check_ready("t3_release_ready", 4'b0010);
    tick();
    check_result("t3_release", 1'b1, 4'b0010, 2'd1);

    // T4: requesters 0 and 3 alternate, starting from pointer 0
    apply_stimulus(4'b1000, 16'h0000, 1'b1);
    tick();
    apply_stimulus(4'b1001, 16'h0000, 1'b1);
    for (int k = 0; k < 7; k++) begin
      check_ready("t4_ready", t4_exp[k]);
      tick();
      check_output("t4_id", 32'(bus.out_id), (k % 2 == 0) ? 32'd0 : 32'd3);
    end

    // T5: reset while full under backpressure (pointer is 1 here)
    apply_stimulus(4'b1001, 16'h0000, 1'b0);
    check_ready("t5_hold_ready", 4'b0000);
    tick();
    rst = 1'b1;
    tick();
    check_result("t5_reset", 1'b0, 4'h0, 2'd0);
    rst = 1'b0;
    apply_stimulus(4'b1001, 16'h000A, 1'b1);
    check_ready("t5_first_ready", 4'b0001);
    tick();
    check_result("t5_first", 1'b1, 4'b1111, 2'd0);

    // T6: requester 2 alone sends 0..15
    for (int b = 0; b < 16; b++) begin
      apply_stimulus(4'b0100, 16'(b << 8), 1'b1);
      tick();
      check_result("t6", 1'b1, gray_tab[b], 2'd2);
    end

    // Drain and idle
    apply_stimulus(4'b0000, 16'h0000, 1'b1);
    tick();
    check_result("drain", 1'b0, 4'h8, 2'd2);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
